z_writeback: RTL and testbench
==============================

# z_writeback

Result write-back sequencer for the datapath ALU. Captures the 64-bit ALU result into an internal Z register on a start pulse, holds the HI/LO register pair, and drives the result onto the 32-bit destination bus with one write strobe per cycle: GPR, LO then HI, PC, or MAR, according to the opcode class. Sits between the ALU output and the register file, PC and MAR write ports, and replaces ad-hoc ZLO/ZHI gating in the control unit.

## Interface
- DATA_W, 32, width of the bus, HI, LO; the ALU result is 2*DATA_W.
- clk  in  1  clock; all state changes on the rising edge.
- clr  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request; opcode, brn_flag and rc must be valid in the same cycle.
- opcode  in  5  ALU opcode (same encoding as the ALU).
- brn_flag  in  1  branch-taken condition.
- rc  in  2*DATA_W  ALU result.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.
- bus_out  out  DATA_W  write data.
- wr_gpr, wr_lo, wr_hi, wr_pc, wr_mar  out  1 each  write strobes; at most one is high per cycle.
- hi_q, lo_q  out  DATA_W  HI/LO register contents.

## Operation
- States: IDLE, WLO, WHI, DONE.
- IDLE with start=1:
  - Z <= rc.
  - op_q <= opcode.
  - br_q <= brn_flag.
  - Go to WLO.
- start is ignored in any other state. It is not queued.
- WLO: bus_out = Z[DATA_W-1:0]. Strobe by op_q class:
  - add, sub, shr, shl, ror, rol, and, or, neg, not, addi, andi, ori: wr_gpr.
  - mul (01110), div (01111): wr_lo; lo_q <= Z low half; next state WHI.
  - ldw, ldwi, stw: wr_mar.
  - branch (10010): wr_pc if br_q=1, otherwise no strobe.
  - mfhi (10111): bus_out = hi_q, wr_gpr. mflo (11000): bus_out = lo_q, wr_gpr. Z is ignored for both.
  - jr, jal, in, out, nop, halt, and undefined opcodes: no strobe.
- WLO goes to WHI for mul/div and to DONE for every other class.
- WHI: bus_out = Z[2*DATA_W-1:DATA_W], wr_hi=1, hi_q <= Z high half. Go to DONE.
- DONE: done=1. Go to IDLE.
- Z is stored unmodified. Any HI-half encoding applied by the ALU is not corrected here.
- Outputs are a Moore decode of the state and the captured registers. Nothing depends combinationally on start, rc or opcode.

## Timing
- Reset (clr=0, asynchronous) sets:
  - state to IDLE;
  - Z, op_q, br_q, hi_q, lo_q to 0;
  - bus_out to 0;
  - all strobes, busy and done to 0.
- A start pulse at edge 0 produces:
  - single-write ops: strobe in cycle 1, done in cycle 2.
  - mul/div: wr_lo in cycle 1, wr_hi in cycle 2, done in cycle 3.
- bus_out is 0 in IDLE and DONE.
- A new start is accepted in the cycle after done, once back in IDLE. Back-to-back throughput is 3 cycles, or 4 for mul/div.
- clr asserted mid-operation aborts the sequence:
  - Any pending HI write is lost.
  - An LO already written is also cleared.
  - No done pulse is issued.
- mfhi/mflo issued in the first IDLE cycle after a mul/div done returns the new HI/LO value.

## Configuration
- ZWB_FAST_DONE_EN:
  - Defined: the DONE state is removed. done is asserted in the same cycle as the final write (WLO, or WHI for mul/div), and the next state is IDLE. Latency becomes 1 cycle for single-write ops and 2 for mul/div.
  - Undefined: behaviour as specified above.

## Test plan
- Add: start, opcode=00011, rc=64'h0000_0000_0000_0012 -> cycle 1 wr_gpr=1 with bus_out=0x12; cycle 2 done=1; busy is 1 in cycles 1-2 only.
- Mul: opcode=01110, rc=64'h0000_0001_8000_0000 -> cycle 1 wr_lo with bus_out=0x80000000; cycle 2 wr_hi with bus_out=0x1; cycle 3 done; then lo_q=0x80000000 and hi_q=0x1.
- Follow-up moves:
  - mfhi immediately after the mul -> wr_gpr with bus_out=0x1.
  - mflo -> wr_gpr with bus_out=0x80000000.
  - rc=all ones on both ignored.
- Branch, not taken: opcode=10010, brn_flag=0, rc=0x40 -> no strobe in cycle 1; done in cycle 2.
- Branch, taken: brn_flag=1 -> wr_pc with bus_out=0x40.
- Abort and overlap:
  - start pulsed during WLO of a div is ignored.
  - clr=0 during WHI -> all outputs 0 immediately; hi_q=lo_q=0; no wr_hi and no done.
- With ZWB_FAST_DONE_EN:
  - div -> done coincides with wr_hi in cycle 2.
  - add -> done coincides with wr_gpr in cycle 1.
  - A new start in the following cycle is accepted.

Source files
------------

// File: rtl/z_writeback_if.sv
// Write-back port bundle: ALU-result request side plus destination bus, strobes and HI/LO view.
// start is a one-cycle request sampled only while busy is low; there is no ready, and a start seen while busy is dropped.
interface z_writeback_if #(parameter int DATA_W = 32);
  logic                  start;
  logic [4:0]            opcode;
  logic                  brn_flag;
  logic [2*DATA_W-1:0]   rc;
  logic                  busy;
  logic                  done;
  logic [DATA_W-1:0]     bus_out;
  logic                  wr_gpr;
  logic                  wr_lo;
  logic                  wr_hi;
  logic                  wr_pc;
  logic                  wr_mar;
  logic [DATA_W-1:0]     hi_q;
  logic [DATA_W-1:0]     lo_q;

  modport master (
    output start, opcode, brn_flag, rc,
    input  busy, done, bus_out, wr_gpr, wr_lo, wr_hi, wr_pc, wr_mar, hi_q, lo_q
  );

  modport slave (
    input  start, opcode, brn_flag, rc,
    output busy, done, bus_out, wr_gpr, wr_lo, wr_hi, wr_pc, wr_mar, hi_q, lo_q
  );
endinterface

// File: rtl/z_writeback.sv
// ALU result write-back sequencer: captures Z, then strobes GPR / LO+HI / PC / MAR one write per cycle.
// Optional ZWB_FAST_DONE_EN drops the DONE state and raises done alongside the final write.
module z_writeback #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              clr,
  z_writeback_if.slave      zb,
  output logic [1:0]        state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WLO  = 2'd1,
    WHI  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [4:0] OP_LDW  = 5'b00000;
  localparam logic [4:0] OP_LDWI = 5'b00001;
  localparam logic [4:0] OP_STW  = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_SHR  = 5'b00101;
  localparam logic [4:0] OP_SHL  = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_AND  = 5'b01001;
  localparam logic [4:0] OP_OR   = 5'b01010;
  localparam logic [4:0] OP_ADDI = 5'b01011;
  localparam logic [4:0] OP_ANDI = 5'b01100;
  localparam logic [4:0] OP_ORI  = 5'b01101;
  localparam logic [4:0] OP_MUL  = 5'b01110;
  localparam logic [4:0] OP_DIV  = 5'b01111;
  localparam logic [4:0] OP_NEG  = 5'b10000;
  localparam logic [4:0] OP_NOT  = 5'b10001;
  localparam logic [4:0] OP_BR   = 5'b10010;
  localparam logic [4:0] OP_MFHI = 5'b10111;
  localparam logic [4:0] OP_MFLO = 5'b11000;

  state_t                state;
  logic [2*DATA_W-1:0]   z;
  logic [4:0]            op_q;
  logic                  br_q;
  logic [DATA_W-1:0]     hi_q;
  logic [DATA_W-1:0]     lo_q;
  logic                  op_muldiv;

  assign op_muldiv = (op_q == OP_MUL) || (op_q == OP_DIV);

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state <= IDLE;
      z     <= '0;
      op_q  <= '0;
      br_q  <= 1'b0;
      hi_q  <= '0;
      lo_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (zb.start) begin
            z     <= zb.rc;
            op_q  <= zb.opcode;
            br_q  <= zb.brn_flag;
            state <= WLO;
          end
        end
        WLO: begin
          if (op_muldiv) begin
            lo_q  <= z[DATA_W-1:0];
            state <= WHI;
          end else begin
`ifdef ZWB_FAST_DONE_EN
            state <= IDLE;
`else
            state <= DONE;
`endif
          end
        end
        WHI: begin
          hi_q <= z[2*DATA_W-1:DATA_W];
`ifdef ZWB_FAST_DONE_EN
          state <= IDLE;
`else
          state <= DONE;
`endif
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Moore decode: every output is a function of state and captured registers only.
  always_comb begin
    zb.bus_out = '0;
    zb.wr_gpr  = 1'b0;
    zb.wr_lo   = 1'b0;
    zb.wr_hi   = 1'b0;
    zb.wr_pc   = 1'b0;
    zb.wr_mar  = 1'b0;
    zb.done    = 1'b0;
    case (state)
      WLO: begin
        zb.bus_out = z[DATA_W-1:0];
        case (op_q)
          OP_ADD, OP_SUB, OP_SHR, OP_SHL, OP_ROR, OP_ROL, OP_AND, OP_OR,
          OP_NEG, OP_NOT, OP_ADDI, OP_ANDI, OP_ORI: zb.wr_gpr = 1'b1;
          OP_MUL, OP_DIV:                           zb.wr_lo  = 1'b1;
          OP_LDW, OP_LDWI, OP_STW:                  zb.wr_mar = 1'b1;
          OP_BR:                                    zb.wr_pc  = br_q;
          OP_MFHI: begin
            zb.bus_out = hi_q;
            zb.wr_gpr  = 1'b1;
          end
          OP_MFLO: begin
            zb.bus_out = lo_q;
            zb.wr_gpr  = 1'b1;
          end
          default: ;
        endcase
`ifdef ZWB_FAST_DONE_EN
        zb.done = !op_muldiv;
`endif
      end
      WHI: begin
        zb.bus_out = z[2*DATA_W-1:DATA_W];
        zb.wr_hi   = 1'b1;
`ifdef ZWB_FAST_DONE_EN
        zb.done    = 1'b1;
`endif
      end
      DONE:    zb.done = 1'b1;
      default: ;
    endcase
  end

  assign zb.busy   = (state != IDLE);
  assign zb.hi_q   = hi_q;
  assign zb.lo_q   = lo_q;
  assign state_dbg = state;

endmodule

// File: tb/tb_z_writeback.sv
// Bench for z_writeback: directed vector table, abort sequence, and randomized ops against a trace model.
module tb_z_writeback;
  localparam int W = 32;
`ifdef ZWB_FAST_DONE_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  localparam logic [4:0] S_NONE = 5'b00000;
  localparam logic [4:0] S_GPR  = 5'b10000;
  localparam logic [4:0] S_LO   = 5'b01000;
  localparam logic [4:0] S_HI   = 5'b00100;
  localparam logic [4:0] S_PC   = 5'b00010;
  localparam logic [4:0] S_MAR  = 5'b00001;

  localparam int C_NONE = 0, C_GPR = 1, C_MULDIV = 2, C_MAR = 3, C_BR = 4, C_MFHI = 5, C_MFLO = 6;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       clr = 1'b0;
  logic [1:0] state_dbg;
  always #5 clk = ~clk;

  z_writeback_if #(.DATA_W(W)) zb();
  z_writeback #(.DATA_W(W)) dut (
    .clk       (clk),
    .clr       (clr),
    .zb        (zb.slave),
    .state_dbg (state_dbg)
  );

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [38:0]  exp_q[$];
  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;

  typedef struct {
    logic [4:0]  op;
    logic        br;
    logic [63:0] rc;
    logic [4:0]  s;
    logic [31:0] bus;
  } vec_t;
  vec_t tbl[12];

  // word layout: {busy, done, wr_gpr, wr_lo, wr_hi, wr_pc, wr_mar, bus_out}
  function automatic logic [38:0] w(input logic busy, input logic done, input logic [4:0] s,
                                    input logic [31:0] bus);
    return {busy, done, s, bus};
  endfunction

  function automatic logic [38:0] observe();
    return {zb.busy, zb.done, zb.wr_gpr, zb.wr_lo, zb.wr_hi, zb.wr_pc, zb.wr_mar, zb.bus_out};
  endfunction

  function automatic int ref_cls(input logic [4:0] op);
    case (op)
      5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11, 5'd12, 5'd13, 5'd16, 5'd17: return C_GPR;
      5'd14, 5'd15:      return C_MULDIV;
      5'd0, 5'd1, 5'd2:  return C_MAR;
      5'd18:             return C_BR;
      5'd23:             return C_MFHI;
      5'd24:             return C_MFLO;
      default:           return C_NONE;
    endcase
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // ---------------- driver + model ----------------
  // Call at a negedge while the DUT is idle; returns at the negedge of the idle cycle after the op.
  task automatic run_op(input logic [4:0] op, input logic br, input logic [63:0] rc,
                        input bit poke, output logic [38:0] first);
    int          cls;
    int          idx;
    logic [4:0]  s;
    logic [31:0] bus;
    logic [38:0] act_w;
    logic [38:0] exp_w;
    cls = ref_cls(op);
    s   = S_NONE;
    bus = rc[31:0];
    first = '0;
    if (cls == C_MULDIV) begin
      exp_q.push_back(w(1'b1, 1'b0, S_LO, rc[31:0]));
      exp_q.push_back(w(1'b1, FAST, S_HI, rc[63:32]));
    end else begin
      case (cls)
        C_GPR:   s = S_GPR;
        C_MAR:   s = S_MAR;
        C_BR:    s = br ? S_PC : S_NONE;
        C_MFHI:  begin s = S_GPR; bus = m_hi; end
        C_MFLO:  begin s = S_GPR; bus = m_lo; end
        default: s = S_NONE;
      endcase
      exp_q.push_back(w(1'b1, FAST, s, bus));
    end
    if (!FAST) exp_q.push_back(w(1'b1, 1'b1, S_NONE, 32'h0));
    exp_q.push_back(w(1'b0, 1'b0, S_NONE, 32'h0));

    zb.start = 1'b1; zb.opcode = op; zb.brn_flag = br; zb.rc = rc;
    idx = 0;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      exp_w = exp_q.pop_front();
      act_w = observe();
      if (idx == 0) first = act_w;
      zb.start    = (idx == 0) && poke;
      zb.opcode   = 5'($urandom_range(0, 31));
      zb.brn_flag = 1'($urandom_range(0, 1));
      zb.rc       = {$urandom, $urandom};
      check($sformatf("op%02h_cyc%0d", op, idx + 1), {25'h0, act_w}, {25'h0, exp_w});
      idx++;
    end
    if (cls == C_MULDIV) begin
      m_lo = rc[31:0];
      m_hi = rc[63:32];
    end
    check($sformatf("op%02h_hi_q", op), {32'h0, zb.hi_q}, {32'h0, m_hi});
    check($sformatf("op%02h_lo_q", op), {32'h0, zb.lo_q}, {32'h0, m_lo});
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [38:0] first;
    logic [4:0]  op;
    logic [63:0] rc;

    tbl[0]  = '{5'b00011, 1'b0, 64'h0000_0000_0000_0012, S_GPR,  32'h0000_0012};
    tbl[1]  = '{5'b01110, 1'b0, 64'h0000_0001_8000_0000, S_LO,   32'h8000_0000};
    tbl[2]  = '{5'b10111, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, S_GPR,  32'h0000_0001};
    tbl[3]  = '{5'b11000, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, S_GPR,  32'h8000_0000};
    tbl[4]  = '{5'b10010, 1'b0, 64'h0000_0000_0000_0040, S_NONE, 32'h0000_0040};
    tbl[5]  = '{5'b10010, 1'b1, 64'h0000_0000_0000_0040, S_PC,   32'h0000_0040};
    tbl[6]  = '{5'b00000, 1'b0, 64'h1234_5678_DEAD_BEEF, S_MAR,  32'hDEAD_BEEF};
    tbl[7]  = '{5'b00010, 1'b1, 64'h0000_0000_0000_0100, S_MAR,  32'h0000_0100};
    tbl[8]  = '{5'b11001, 1'b1, 64'h0000_0000_0000_0077, S_NONE, 32'h0000_0077};
    tbl[9]  = '{5'b10100, 1'b0, 64'h0000_0000_0000_0055, S_NONE, 32'h0000_0055};
    tbl[10] = '{5'b11111, 1'b1, 64'h0000_0000_CAFE_F00D, S_NONE, 32'hCAFE_F00D};
    tbl[11] = '{5'b10000, 1'b0, 64'h0000_0000_FFFF_FFFE, S_GPR,  32'hFFFF_FFFE};

    zb.start = 1'b0; zb.opcode = '0; zb.brn_flag = 1'b0; zb.rc = '0;

    // reset state
    #1;
    check("reset_outputs", {25'h0, observe()}, 64'h0);
    check("reset_hi_lo",   {zb.hi_q, zb.lo_q}, 64'h0);
    check("reset_state",   {62'h0, state_dbg}, 64'h0);
    @(negedge clk);
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);

    // directed vector table
    for (int i = 0; i < 12; i++) begin
      run_op(tbl[i].op, tbl[i].br, tbl[i].rc, 1'b0, first);
      check($sformatf("tbl%0d_first", i), {27'h0, first[36:0]}, {27'h0, tbl[i].s, tbl[i].bus});
    end

    // abort: div, ignored start during WLO, clr during WHI
    rc = 64'hAAAA_5555_1234_4321;
    zb.start = 1'b1; zb.opcode = 5'b01111; zb.brn_flag = 1'b0; zb.rc = rc;
    @(negedge clk);
    check("abort_wlo", {25'h0, observe()}, {25'h0, w(1'b1, 1'b0, S_LO, 32'h1234_4321)});
    zb.opcode = 5'b00011; zb.rc = 64'h0000_0000_0000_0099;
    @(negedge clk);
    zb.start = 1'b0;
    check("abort_whi", {25'h0, observe()}, {25'h0, w(1'b1, FAST, S_HI, 32'hAAAA_5555)});
    check("abort_lo_written", {32'h0, zb.lo_q}, 64'h0000_0000_1234_4321);
    clr = 1'b0;
    #1;
    check("abort_outputs", {25'h0, observe()}, 64'h0);
    check("abort_hi_lo",   {zb.hi_q, zb.lo_q}, 64'h0);
    @(negedge clk);
    clr = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("abort_quiet%0d", i), {25'h0, observe()}, 64'h0);
    end
    m_hi = '0;
    m_lo = '0;

    // randomized ops, back to back
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2: op = 5'($urandom_range(14, 15));
        3:       op = 5'd23;
        4:       op = 5'd24;
        default: op = 5'($urandom_range(0, 31));
      endcase
      rc = {$urandom, $urandom};
      run_op(op, 1'($urandom_range(0, 1)), rc, bit'($urandom_range(0, 1)), first);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
